seq_shifter: RTL and testbench

- Parametrised, multi-cycle shift/rotate unit; generalises the fixed left-by-1 offset shifter.
- Shifts a WIDTH-bit operand by a run-time amount in one of four modes (SLL, SRL, SRA, ROL).
- Advances up to STEP bit positions per clock, with a start/busy/done handshake.
- Sits beside the ALU for multi-bit shift instructions; the control FSM stalls on busy.

---
 rtl/seq_shifter_if.sv | 18 +
 rtl/seq_shifter.sv | 95 +++++++++
 tb/tb_seq_shifter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_shifter_if.sv
// Handshake/data bundle between the ALU control FSM (master) and the
// multi-cycle shift/rotate unit (slave).
interface seq_shifter_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);
   logic             start;
   logic [WIDTH-1:0] in;
   logic [AMT_W-1:0] amt;
   logic [1:0]       mode;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             carry;

   modport master (output start, in, amt, mode, input busy, done, out, carry);
   modport slave  (input start, in, amt, mode, output busy, done, out, carry);
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL unit: shifts up to STEP positions per clock,
// start/busy/done handshake, result held in the work register.
module seq_shifter #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4,
   parameter int STEP  = 1
) (
   input logic          clk,
   input logic          reset,
   seq_shifter_if.slave bus
);
   // Per-cycle step clamped to the largest legal amount so it fits AMT_W bits.
   localparam int               MAX_AMT  = (1 << AMT_W) - 1;
   localparam int               STEP_CAP = (STEP < MAX_AMT) ? STEP : MAX_AMT;
   localparam logic [AMT_W-1:0] STEP_V   = STEP_CAP[AMT_W-1:0];

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work, work_nxt;
   logic [AMT_W-1:0] rem, rem_nxt, k;
   logic [1:0]       mode_q, mode_nxt;
   logic             carry_q, carry_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         work    <= '0;
         rem     <= '0;
         mode_q  <= '0;
         carry_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         work    <= work_nxt;
         rem     <= rem_nxt;
         mode_q  <= mode_nxt;
         carry_q <= carry_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      work_nxt  = work;
      rem_nxt   = rem;
      mode_nxt  = mode_q;
      carry_nxt = carry_q;
      k         = (rem > STEP_V) ? STEP_V : rem;
      case (state)
         IDLE: begin
            if (bus.start) begin
               work_nxt  = bus.in;
               rem_nxt   = bus.amt;
               mode_nxt  = bus.mode;
               carry_nxt = 1'b0;
               state_nxt = (bus.amt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            // Unrolled single-bit steps; only the first k take effect, so the
            // final partial step still leaves carry as the last bit out.
            for (int s = 0; s < STEP; s++) begin
               if (s < int'(k)) begin
                  case (mode_q)
                     2'b00: begin
                        carry_nxt = work_nxt[WIDTH-1];
                        work_nxt  = {work_nxt[WIDTH-2:0], 1'b0};
                     end
                     2'b01: begin
                        carry_nxt = work_nxt[0];
                        work_nxt  = {1'b0, work_nxt[WIDTH-1:1]};
                     end
                     2'b10: begin
                        carry_nxt = work_nxt[0];
                        work_nxt  = {work_nxt[WIDTH-1], work_nxt[WIDTH-1:1]};
                     end
                     default: begin
                        carry_nxt = work_nxt[WIDTH-1];
                        work_nxt  = {work_nxt[WIDTH-2:0], work_nxt[WIDTH-1]};
                     end
                  endcase
               end
            end
            rem_nxt = rem - k;
            if (rem_nxt == '0) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy  = (state == SHIFT);
   assign bus.done  = (state == DONE);
   assign bus.out   = work;
   assign bus.carry = carry_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench: STEP=1 and STEP=4 instances share operands; a negedge
// monitor pops expected {out, carry, busy-cycles} whenever done is seen.
module tb_seq_shifter;
   localparam int W = 16;
   localparam int A = 4;

   typedef struct {
      logic [W-1:0] out;
      logic         carry;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   st;
   logic [W-1:0] d_in;
   logic [A-1:0] d_amt;
   logic [1:0]   d_mode;

   int   tests = 0;
   int   fails = 0;
   int   ndone [2];
   int   bcnt  [2];
   exp_t q0[$];
   exp_t q1[$];
   exp_t me;
   bit   mgot;

   always #5 clk = ~clk;

   seq_shifter_if #(.WIDTH(W), .AMT_W(A)) b1 ();
   seq_shifter_if #(.WIDTH(W), .AMT_W(A)) b4 ();

   assign b1.start = st[0];
   assign b1.in    = d_in;
   assign b1.amt   = d_amt;
   assign b1.mode  = d_mode;
   assign b4.start = st[1];
   assign b4.in    = d_in;
   assign b4.amt   = d_amt;
   assign b4.mode  = d_mode;

   seq_shifter #(.WIDTH(W), .AMT_W(A), .STEP(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
   seq_shifter #(.WIDTH(W), .AMT_W(A), .STEP(4)) u4 (.clk(clk), .reset(reset), .bus(b4));

   logic         dn  [2];
   logic         bsy [2];
   logic [W-1:0] o   [2];
   logic         c   [2];
   assign dn[0] = b1.done;  assign bsy[0] = b1.busy;  assign o[0] = b1.out;  assign c[0] = b1.carry;
   assign dn[1] = b4.done;  assign bsy[1] = b4.busy;  assign o[1] = b4.out;  assign c[1] = b4.carry;

   // Reference: whole-operation shift using plain operators.
   function automatic exp_t model(input logic [W-1:0] i, input int a, input logic [1:0] m,
                                  input int step);
      exp_t e;
      e.cyc   = (a + step - 1) / step;
      e.out   = i;
      e.carry = 1'b0;
      if (a != 0) begin
         case (m)
            2'b00: begin e.out = i << a;            e.carry = i[W-a]; end
            2'b01: begin e.out = i >> a;            e.carry = i[a-1]; end
            2'b10: begin e.out = $signed(i) >>> a;  e.carry = i[a-1]; end
            default: begin
               e.out   = (i << a) | (i >> (W - a));
               e.carry = e.out[0];
            end
         endcase
      end
      return e;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) bcnt[d] = 0;
         else if (dn[d]) begin
            mgot = 1'b0;
            if (d == 0 && q0.size() > 0) begin me = q0.pop_front(); mgot = 1'b1; end
            if (d == 1 && q1.size() > 0) begin me = q1.pop_front(); mgot = 1'b1; end
            tests++;
            if (!mgot) begin
               fails++;
               $display("FAIL unexpected_done dut%0d out=%h carry=%b", d, o[d], c[d]);
            end else if (o[d] !== me.out || c[d] !== me.carry || bcnt[d] != me.cyc) begin
               fails++;
               $display("FAIL result dut%0d got out=%h carry=%b busy=%0d exp out=%h carry=%b busy=%0d",
                        d, o[d], c[d], bcnt[d], me.out, me.carry, me.cyc);
            end
            bcnt[d] = 0;
            ndone[d]++;
         end else if (bsy[d]) bcnt[d]++;
      end
   end

   task automatic chk(input string n, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at #1 after an edge with the targeted DUTs idle.
   task automatic issue(input logic [1:0] which, input logic [W-1:0] i, input logic [A-1:0] a,
                        input logic [1:0] m);
      if (which[0]) q0.push_back(model(i, int'(a), m, 1));
      if (which[1]) q1.push_back(model(i, int'(a), m, 4));
      d_in = i; d_amt = a; d_mode = m; st = which;
      tick();
      st = 2'b00;
   endtask

   task automatic wait_both(input int n0, input int n1);
      int t = 0;
      while ((ndone[0] < n0 || ndone[1] < n1) && t < 100) begin tick(); t++; end
      if (t >= 100) begin
         tests++; fails++;
         $display("FAIL timeout got done=%0d/%0d exp %0d/%0d", ndone[0], ndone[1], n0, n1);
      end
   endtask

   task automatic run(input logic [W-1:0] i, input logic [A-1:0] a, input logic [1:0] m);
      int n0 = ndone[0] + 1;
      int n1 = ndone[1] + 1;
      issue(2'b11, i, a, m);
      wait_both(n0, n1);
   endtask

   task automatic wait_done(input int d);
      int t = 0;
      while (!dn[d] && t < 50) begin tick(); t++; end
      if (t >= 50) begin
         tests++; fails++;
         $display("FAIL wait_done dut%0d got no done exp done", d);
      end
   endtask

   task automatic chk_zero(input string n);
      for (int d = 0; d < 2; d++) begin
         chk({n, "_busy"},  int'(bsy[d]), 0);
         chk({n, "_done"},  int'(dn[d]),  0);
         chk({n, "_out"},   int'(o[d]),   0);
         chk({n, "_carry"}, int'(c[d]),   0);
      end
   endtask

   initial begin
      int n0, n1;
      ndone = '{0, 0};
      bcnt  = '{0, 0};
      reset = 1'b1; st = 2'b00; d_in = '0; d_amt = '0; d_mode = '0;
      repeat (2) tick();
      chk_zero("reset");
      reset = 1'b0;
      tick();

      run(16'hFFFF, 4'd1, 2'b00);
      run(16'h8001, 4'd4, 2'b10);
      run(16'h8001, 4'd1, 2'b11);
      run(16'h1234, 4'd0, 2'b01);
      run(16'hABCD, 4'd15, 2'b01);
      run(16'h7FFF, 4'd15, 2'b11);
      run(16'h8000, 4'd15, 2'b10);

      // Starts during SHIFT and during DONE must be ignored.
      n0 = ndone[0] + 1;
      n1 = ndone[1] + 1;
      issue(2'b11, 16'h5A5A, 4'd15, 2'b11);
      tick();
      d_in = 16'hFFFF; d_amt = 4'd3; d_mode = 2'b00; st = 2'b11;
      tick();
      st = 2'b00;
      wait_done(1);
      st = 2'b10; d_in = 16'h1111; d_amt = 4'd2;
      tick();
      st = 2'b00;
      wait_done(0);
      st = 2'b01; d_in = 16'h2222; d_amt = 4'd5;
      tick();
      st = 2'b00;
      wait_both(n0, n1);
      repeat (20) tick();
      chk("ignore_done_count0", ndone[0], n0);
      chk("ignore_done_count1", ndone[1], n1);

      // Reset on the second SHIFT cycle aborts without a done pulse.
      n0 = ndone[0];
      n1 = ndone[1];
      issue(2'b11, 16'hF0F0, 4'd8, 2'b00);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q0.delete();
      q1.delete();
      chk_zero("abort");
      repeat (3) tick();
      chk("abort_no_done0", ndone[0], n0);
      chk("abort_no_done1", ndone[1], n1);
      run(16'hC3A5, 4'd9, 2'b10);

      repeat (40) run(W'($urandom), A'($urandom), 2'($urandom));

      repeat (3) tick();
      chk("queue_empty0", q0.size(), 0);
      chk("queue_empty1", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
